// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory stage.
//   - access size encodings (SZ_B, SZ_H, SZ_W, SZ_D)
//   - controller state enum (IDLE, ACC0, ACC1, FAULT)
//   - size_bytes(): number of bytes touched by an access, 2^Size
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC0  = 2'd1,
    ACC1  = 2'd2,
    FAULT = 2'd3
  } state_e;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for one dword beat.
// Store path: the access is viewed as a 16-byte window spanning the dword
// holding the first byte (beat 0) and the next one (beat 1); the mask and
// data for the selected beat are returned.
// Load path: the two dwords are concatenated, shifted down by the lane
// offset and the result is sign- or zero-extended from the access size.
// Ports:
//   offset      in  3   byte lane of the first accessed byte
//   beat        in  1   0: first dword, 1: following dword
//   size        in  2   access size (SZ_*)
//   wdata       in  64  unshifted store data
//   byte_en     out 8   byte enables for the selected dword
//   wdata_lane  out 64  store data placed on its byte lanes
//   is_unsigned in  1   zero-extend (1) or sign-extend (0) loads
//   rdata_lo    in  64  dword holding the first byte
//   rdata_hi    in  64  following dword (only meaningful for crossing loads)
//   rdata_ext   out 64  assembled and extended load result
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  offset,
  input  logic        beat,
  input  logic [1:0]  size,
  input  logic [63:0] wdata,
  output logic [7:0]  byte_en,
  output logic [63:0] wdata_lane,
  input  logic        is_unsigned,
  input  logic [63:0] rdata_lo,
  input  logic [63:0] rdata_hi,
  output logic [63:0] rdata_ext
);

  logic [7:0]   mask8_s;
  logic [15:0]  mask16_s;
  logic [127:0] wide_w_s;
  logic [63:0]  raw_s;

  // Store path: byte mask and shifted data over a two-dword window.
  always_comb begin
    case (size)
      SZ_B:    mask8_s = 8'h01;
      SZ_H:    mask8_s = 8'h03;
      SZ_W:    mask8_s = 8'h0F;
      default: mask8_s = 8'hFF;
    endcase
    mask16_s = {8'h00, mask8_s} << offset;
    wide_w_s = {64'd0, wdata} << {offset, 3'b000};
    if (beat) begin
      byte_en    = mask16_s[15:8];
      wdata_lane = wide_w_s[127:64];
    end else begin
      byte_en    = mask16_s[7:0];
      wdata_lane = wide_w_s[63:0];
    end
  end

  // Load path: realign to bit 0, then extend from the top bit of the access.
  always_comb begin
    raw_s = 64'({rdata_hi, rdata_lo} >> {offset, 3'b000});
    case (size)
      SZ_B:    rdata_ext = is_unsigned ? {56'd0, raw_s[7:0]}
                                       : {{56{raw_s[7]}}, raw_s[7:0]};
      SZ_H:    rdata_ext = is_unsigned ? {48'd0, raw_s[15:0]}
                                       : {{48{raw_s[15]}}, raw_s[15:0]};
      SZ_W:    rdata_ext = is_unsigned ? {32'd0, raw_s[31:0]}
                                       : {{32{raw_s[31]}}, raw_s[31:0]};
      default: rdata_ext = raw_s;
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// data_mem_unit: byte/half/word/dword load-store unit over a DEPTH x 64-bit
// little-endian array, with a request/done handshake and fault reporting.
// Optional feature macro: DMEM_MISALIGN_SPLIT_EN. When defined, misaligned
// accesses are legal and those crossing a dword boundary take a second
// access beat (ACC1). When undefined, misaligned accesses fault and every
// legal access completes after one beat.
// Ports:
//   clk        in  1   rising-edge clock
//   reset      in  1   synchronous active-high reset (array is not cleared)
//   MemRead    in  1   load request (sampled while Busy=0)
//   MemWrite   in  1   store request (sampled while Busy=0)
//   Addr       in  64  byte address
//   WriteData  in  64  store data, low 8*2^Size bits used
//   Size       in  2   00 byte, 01 half, 10 word, 11 dword
//   Unsigned   in  1   load zero-extend (1) / sign-extend (0)
//   ReadData   out 64  load result, valid with Done
//   Busy       out 1   request in progress
//   Done       out 1   one-cycle completion pulse
//   Fault      out 1   request rejected (with Done)
module data_mem_unit
  import dmem_pkg::*;
#(
  parameter int DEPTH = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [63:0] Addr,
  input  logic [63:0] WriteData,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  output logic [63:0] ReadData,
  output logic        Busy,
  output logic        Done,
  output logic        Fault
);

  localparam int          AW    = $clog2(DEPTH);
  localparam logic [63:0] LIMIT = 64'(DEPTH) << 3;

  state_e        state_r, state_n;
  logic [63:0]   mem_r [DEPTH];
  logic [AW+2:0] addr_r;
  logic [63:0]   wdata_r;
  logic [1:0]    size_r;
  logic          uns_r;
  logic          wr_r;

  logic [3:0]    nbytes_s;
  logic          illegal_s;
  logic          accept_s;
  logic          beat_s;
  logic          mem_we_s;
  logic [AW-1:0] idx_s;
  logic [63:0]   mem_rd_s;
  logic [63:0]   lo_in_s;
  logic [63:0]   rdata_ext_s;
  logic [63:0]   load_res_s;
  logic [63:0]   wdata_lane_s;
  logic [7:0]    byte_en_s;
  logic          done_n;
  logic          fault_n;
  logic [63:0]   rdata_n;

`ifdef DMEM_MISALIGN_SPLIT_EN
  logic          crossing_s;
  logic [63:0]   lo_r;
  logic [63:0]   lo_n;
`endif

  assign accept_s = (state_r == IDLE) && (MemRead || MemWrite);

  // Legality of the request on the inputs; only used at acceptance.
  always_comb begin
    nbytes_s  = size_bytes(Size);
    illegal_s = 1'b0;
    if (MemRead && MemWrite) begin
      illegal_s = 1'b1;
    end else if (Addr > (LIMIT - 64'(nbytes_s))) begin
      // Last byte at or beyond the array end; written this way so huge
      // addresses cannot wrap the sum back into range.
      illegal_s = 1'b1;
`ifndef DMEM_MISALIGN_SPLIT_EN
    end else if ((Addr[2:0] & 3'(nbytes_s - 4'd1)) != 3'd0) begin
      illegal_s = 1'b1;
`endif
    end else begin
      illegal_s = 1'b0;
    end
  end

`ifdef DMEM_MISALIGN_SPLIT_EN
  assign beat_s     = (state_r == ACC1);
  assign crossing_s = ({1'b0, addr_r[2:0]} + size_bytes(size_r)) > 4'd8;
  assign lo_in_s    = beat_s ? lo_r : mem_rd_s;
`else
  assign beat_s     = 1'b0;
  assign lo_in_s    = mem_rd_s;
`endif

  // ACC1 addresses the dword after the first; range check guarantees it exists.
  assign idx_s      = addr_r[AW+2:3] + AW'(beat_s);
  assign mem_rd_s   = mem_r[idx_s];
  assign mem_we_s   = wr_r && ((state_r == ACC0) || (state_r == ACC1)) && !reset;
  assign load_res_s = wr_r ? 64'd0 : rdata_ext_s;

  dmem_lane_align u_align (
    .offset      (addr_r[2:0]),
    .beat        (beat_s),
    .size        (size_r),
    .wdata       (wdata_r),
    .byte_en     (byte_en_s),
    .wdata_lane  (wdata_lane_s),
    .is_unsigned (uns_r),
    .rdata_lo    (lo_in_s),
    .rdata_hi    (mem_rd_s),
    .rdata_ext   (rdata_ext_s)
  );

  // Byte-lane merge into the addressed dword; reset cancels a pending beat.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < 8; i++) begin
        if (byte_en_s[i]) begin
          mem_r[idx_s][8*i +: 8] <= wdata_lane_s[8*i +: 8];
        end
      end
    end
  end

  // Next state and next completion outputs.
  always_comb begin
    state_n = state_r;
    done_n  = 1'b0;
    fault_n = 1'b0;
    rdata_n = 64'd0;
`ifdef DMEM_MISALIGN_SPLIT_EN
    lo_n    = lo_r;
`endif
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_n = illegal_s ? FAULT : ACC0;
        end else begin
          state_n = IDLE;
        end
      end
      ACC0: begin
`ifdef DMEM_MISALIGN_SPLIT_EN
        if (crossing_s) begin
          state_n = ACC1;
          lo_n    = mem_rd_s;
        end else begin
          state_n = IDLE;
          done_n  = 1'b1;
          rdata_n = load_res_s;
        end
`else
        state_n = IDLE;
        done_n  = 1'b1;
        rdata_n = load_res_s;
`endif
      end
`ifdef DMEM_MISALIGN_SPLIT_EN
      ACC1: begin
        state_n = IDLE;
        done_n  = 1'b1;
        rdata_n = load_res_s;
      end
`endif
      FAULT: begin
        state_n = IDLE;
        done_n  = 1'b1;
        fault_n = 1'b1;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Fault    <= 1'b0;
      ReadData <= 64'd0;
    end else begin
      state_r  <= state_n;
      Busy     <= (state_n != IDLE);
      Done     <= done_n;
      Fault    <= fault_n;
      ReadData <= rdata_n;
    end
  end

  // Request capture on acceptance, plus the low-dword hold for split loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_r  <= {(AW+3){1'b0}};
      wdata_r <= 64'd0;
      size_r  <= SZ_B;
      uns_r   <= 1'b0;
      wr_r    <= 1'b0;
`ifdef DMEM_MISALIGN_SPLIT_EN
      lo_r    <= 64'd0;
`endif
    end else begin
      if (accept_s) begin
        addr_r  <= Addr[AW+2:0];
        wdata_r <= WriteData;
        size_r  <= Size;
        uns_r   <= Unsigned;
        wr_r    <= MemWrite;
      end
`ifdef DMEM_MISALIGN_SPLIT_EN
      lo_r <= lo_n;
`endif
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
module tb_data_mem_unit;

  localparam int DEPTH = 512;
  localparam int NBYTE = DEPTH * 8;
  localparam longint unsigned LIMIT = 64'(NBYTE);
`ifdef DMEM_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite, Unsigned;
  logic [63:0] Addr, WriteData;
  logic [1:0]  Size;
  logic [63:0] ReadData;
  logic        Busy, Done, Fault;

  int tests = 0;
  int fails = 0;

  logic [7:0] ref_mem [0:NBYTE-1];

  typedef struct {
    bit          rd;
    bit          wr;
    logic [63:0] addr;
    logic [63:0] data;
    logic [1:0]  size;
    bit          uns;
    logic [63:0] exp_rdata;
    bit          exp_fault;
    int          exp_lat;
  } vec_t;

  vec_t tbl[$];

  data_mem_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Addr(Addr), .WriteData(WriteData), .Size(Size), .Unsigned(Unsigned),
    .ReadData(ReadData), .Busy(Busy), .Done(Done), .Fault(Fault)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h", name, got, exp);
    end
  endtask

  // ---------------- reference model (byte array) ----------------
  function automatic bit m_legal(bit rd, bit wr, longint unsigned a, int sz);
    longint unsigned n;
    n = longint'(1) << sz;
    if (rd && wr) return 1'b0;
    if (a >= LIMIT || a + n > LIMIT) return 1'b0;
    if (!SPLIT && (a % n) != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int m_lat(bit legal, longint unsigned a, int sz);
    if (!legal) return 2;
    return (((a % 8) + (longint'(1) << sz)) > 8) ? 3 : 2;
  endfunction

  function automatic logic [63:0] m_load(longint unsigned a, int sz, bit uns);
    int n;
    logic [63:0] v;
    n = 1 << sz;
    v = 64'd0;
    for (int i = 0; i < n; i++) v = v | (64'(ref_mem[int'(a) + i]) << (8 * i));
    if (!uns && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
    return v;
  endfunction

  task automatic m_store(longint unsigned a, int sz, logic [63:0] d);
    for (int i = 0; i < (1 << sz); i++) ref_mem[int'(a) + i] = d[8*i +: 8];
  endtask

  // ---------------- stimulus ----------------
  // Called at a negedge; returns at the negedge of the Done cycle.
  task automatic do_req(input bit rd, input bit wr, input logic [63:0] a, input logic [63:0] d,
                        input logic [1:0] sz, input bit uns,
                        output logic [63:0] rdat, output bit flt, output int lat, output int bsy);
    int guard;
    guard = 0;
    while (Busy && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    MemRead = rd; MemWrite = wr; Addr = a; WriteData = d; Size = sz; Unsigned = uns;
    @(posedge clk);
    lat = 0;
    bsy = 0;
    do begin
      @(negedge clk);
      MemRead = 1'b0;
      MemWrite = 1'b0;
      lat++;
      if (!Done) bsy += int'(Busy);
    end while (!Done && lat < 10);
    rdat = ReadData;
    flt  = Fault;
  endtask

  task automatic run_req(input bit rd, input bit wr, input logic [63:0] a, input logic [63:0] d,
                         input logic [1:0] sz, input bit uns,
                         output logic [63:0] rdat, output bit flt, output int lat, output int bsy);
    bit ok;
    ok = m_legal(rd, wr, a, int'(sz));
    do_req(rd, wr, a, d, sz, uns, rdat, flt, lat, bsy);
    if (ok && wr) m_store(a, int'(sz), d);
  endtask

  task automatic add(bit rd, bit wr, logic [63:0] a, logic [63:0] d, logic [1:0] sz, bit uns,
                     logic [63:0] er, bit ef, int el);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.data = d; v.size = sz; v.uns = uns;
    v.exp_rdata = er; v.exp_fault = ef; v.exp_lat = el;
    tbl.push_back(v);
  endtask

  initial begin
    logic [63:0] rdat;
    bit          flt;
    int          lat, bsy;

    for (int i = 0; i < NBYTE; i++) ref_mem[i] = 8'h00;
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Addr = 64'd0;
    WriteData = 64'd0; Size = 2'd0; Unsigned = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset Busy", 64'(Busy), 64'd0);
    check("reset Done", 64'(Done), 64'd0);
    check("reset Fault", 64'(Fault), 64'd0);
    check("reset ReadData", ReadData, 64'd0);

    // ---------------- directed table ----------------
    add(0, 1, 64'h18, 64'h0807060504030201, 2'd3, 0, 64'd0, 0, 2);
    add(0, 1, 64'h20, 64'h100F0E0D0C0B0A09, 2'd3, 0, 64'd0, 0, 2);
    add(0, 1, 64'h10, 64'h0123456789ABCDEF, 2'd3, 0, 64'd0, 0, 2);
    add(1, 0, 64'h10, 64'd0, 2'd3, 0, 64'h0123456789ABCDEF, 0, 2);
    add(1, 0, 64'h17, 64'd0, 2'd0, 0, 64'h0000000000000001, 0, 2);
    add(0, 1, 64'h18, 64'h80, 2'd0, 0, 64'd0, 0, 2);
    add(1, 0, 64'h18, 64'd0, 2'd0, 0, 64'hFFFFFFFFFFFFFF80, 0, 2);
    add(1, 0, 64'h18, 64'd0, 2'd0, 1, 64'h0000000000000080, 0, 2);
    add(0, 1, 64'h12, 64'hBEEF, 2'd1, 0, 64'd0, 0, 2);
    add(1, 0, 64'h10, 64'd0, 2'd3, 0, 64'h01234567BEEFCDEF, 0, 2);
    add(1, 0, 64'h11, 64'd0, 2'd1, 0, SPLIT ? 64'hFFFFFFFFFFFFEFCD : 64'd0, !SPLIT, 2);
    add(0, 1, 64'h1E, 64'hDEADBEEF, 2'd2, 0, 64'd0, !SPLIT, SPLIT ? 3 : 2);
    add(1, 0, 64'h1E, 64'd0, 2'd2, 0, SPLIT ? 64'hFFFFFFFFDEADBEEF : 64'd0, !SPLIT, SPLIT ? 3 : 2);
    add(1, 0, 64'h18, 64'd0, 2'd3, 0, SPLIT ? 64'hBEEF060504030280 : 64'h0807060504030280, 0, 2);
    add(1, 0, 64'h20, 64'd0, 2'd3, 0, SPLIT ? 64'h100F0E0D0C0BDEAD : 64'h100F0E0D0C0B0A09, 0, 2);
    add(1, 0, 64'h10, 64'd0, 2'd3, 1, 64'h01234567BEEFCDEF, 0, 2);
    add(1, 1, 64'h10, 64'h5A5A, 2'd3, 0, 64'd0, 1, 2);
    add(1, 0, 64'h1000, 64'd0, 2'd0, 0, 64'd0, 1, 2);
    add(0, 1, 64'hFF8, 64'hA1B2C3D4E5F60718, 2'd3, 0, 64'd0, 0, 2);
    add(1, 0, 64'hFF8, 64'd0, 2'd3, 0, 64'hA1B2C3D4E5F60718, 0, 2);
    add(0, 1, 64'hFFF, 64'h1234, 2'd1, 0, 64'd0, 1, 2);
    add(1, 0, 64'hFFF, 64'd0, 2'd0, 1, 64'h00000000000000A1, 0, 2);
    add(1, 0, 64'hFFF, 64'd0, 2'd0, 0, 64'hFFFFFFFFFFFFFFA1, 0, 2);
    add(1, 0, 64'hFFFFFFFFFFFFFFFF, 64'd0, 2'd0, 0, 64'd0, 1, 2);
    add(1, 0, 64'hFFC, 64'd0, 2'd2, 1, 64'h00000000A1B2C3D4, 0, 2);
    add(0, 1, 64'hFF9, 64'h7777777777777777, 2'd3, 0, 64'd0, 1, 2);
    add(1, 0, 64'hFF8, 64'd0, 2'd3, 0, 64'hA1B2C3D4E5F60718, 0, 2);

    foreach (tbl[i]) begin
      run_req(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].size, tbl[i].uns,
              rdat, flt, lat, bsy);
      if (tbl[i].rd || tbl[i].exp_fault)
        check($sformatf("vec%0d rdata", i), rdat, tbl[i].exp_rdata);
      check($sformatf("vec%0d fault", i), 64'(flt), 64'(tbl[i].exp_fault));
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(tbl[i].exp_lat));
      check($sformatf("vec%0d busy cycles", i), 64'(bsy), 64'(tbl[i].exp_lat - 1));
    end

    // ---------------- request presented while Busy is dropped ----------------
    MemRead = 1'b1; MemWrite = 1'b0; Addr = 64'h10; Size = 2'd3; Unsigned = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("drop busy in ACC0", 64'(Busy), 64'd1);
    MemRead = 1'b0; MemWrite = 1'b1; WriteData = 64'hDEADDEADDEADDEAD;
    @(posedge clk);
    @(negedge clk);
    check("drop first done", 64'(Done), 64'd1);
    check("drop first rdata", ReadData, 64'h01234567BEEFCDEF);
    MemWrite = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("drop no extra done", 64'(Done), 64'd0);
    check("drop not busy", 64'(Busy), 64'd0);
    run_req(1, 0, 64'h10, 64'd0, 2'd3, 0, rdat, flt, lat, bsy);
    check("drop memory unchanged", rdat, 64'h01234567BEEFCDEF);

    // ---------------- held request accepted once Busy falls ----------------
    MemRead = 1'b1; MemWrite = 1'b0; Addr = 64'h10; Size = 2'd3;
    @(posedge clk);
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b1; Addr = 64'h28; WriteData = 64'h5555AAAA3333CCCC;
    @(posedge clk);
    @(negedge clk);
    check("held done of first", 64'(Done), 64'd1);
    check("held not busy in done cycle", 64'(Busy), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("held accepted busy", 64'(Busy), 64'd1);
    MemWrite = 1'b0;
    m_store(64'h28, 3, 64'h5555AAAA3333CCCC);
    @(posedge clk);
    @(negedge clk);
    check("held store done", 64'(Done), 64'd1);
    check("held store fault", 64'(Fault), 64'd0);
    run_req(1, 0, 64'h28, 64'd0, 2'd3, 0, rdat, flt, lat, bsy);
    check("held store readback", rdat, 64'h5555AAAA3333CCCC);

`ifdef DMEM_MISALIGN_SPLIT_EN
    // ---------------- reset while in ACC1 of a split store ----------------
    run_req(0, 1, 64'h30, 64'h1122334455667788, 2'd3, 0, rdat, flt, lat, bsy);
    run_req(0, 1, 64'h38, 64'h99AABBCCDDEEFF00, 2'd3, 0, rdat, flt, lat, bsy);
    MemWrite = 1'b1; Addr = 64'h34; WriteData = 64'hCAFEBABEF00DD00D; Size = 2'd3;
    @(posedge clk);
    @(negedge clk);
    MemWrite = 1'b0;
    check("split reset busy ACC0", 64'(Busy), 64'd1);
    @(posedge clk);
    @(negedge clk);
    check("split reset busy ACC1", 64'(Busy), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("split reset Busy", 64'(Busy), 64'd0);
    check("split reset Done", 64'(Done), 64'd0);
    m_store(64'h34, 2, 64'hF00DD00D);
    run_req(1, 0, 64'h30, 64'd0, 2'd3, 0, rdat, flt, lat, bsy);
    check("split reset low dword", rdat, 64'hF00DD00D55667788);
    run_req(1, 0, 64'h38, 64'd0, 2'd3, 0, rdat, flt, lat, bsy);
    check("split reset high dword", rdat, 64'h99AABBCCDDEEFF00);
`endif

    // ---------------- randomized against the model ----------------
    for (int a = 'h100; a < 'h200; a += 8) begin
      run_req(0, 1, 64'(a), {$urandom, $urandom}, 2'd3, 0, rdat, flt, lat, bsy);
    end
    for (int k = 0; k < 300; k++) begin
      bit          rd, wr, uns, ok;
      logic [63:0] a, d, er;
      logic [1:0]  sz;
      int          r, el;
      r   = int'($urandom_range(0, 15));
      rd  = (r < 8) || (r == 15);
      wr  = (r >= 8);
      a   = 64'h100 + 64'($urandom_range(0, 247));
      if ($urandom_range(0, 19) == 0) a = LIMIT - 64'($urandom_range(0, 3));
      d   = {$urandom, $urandom};
      sz  = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      ok  = m_legal(rd, wr, a, int'(sz));
      el  = m_lat(ok, a, int'(sz));
      er  = (ok && rd) ? m_load(a, int'(sz), uns) : 64'd0;
      run_req(rd, wr, a, d, sz, uns, rdat, flt, lat, bsy);
      if (rd || !ok) check($sformatf("rnd%0d rdata", k), rdat, er);
      check($sformatf("rnd%0d fault", k), 64'(flt), 64'(!ok));
      check($sformatf("rnd%0d latency", k), 64'(lat), 64'(el));
      check($sformatf("rnd%0d busy cycles", k), 64'(bsy), 64'(el - 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
